// File: rtl/clksw_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clksw_pkg                                                    |
// | Description : Shared types and constants for the N-way divided-clock       |
// |               switcher. Provides the switch FSM state encoding, the        |
// |               upper bound on selectable ratios and a ratio helper.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package clksw_pkg;

    // Largest supported number of selectable ratios.
    localparam int MAX_NUM_DIVS = 8;

    // Switch FSM: waiting for a request, or holding one until alignment.
    typedef enum logic [0:0] {
        IDLE       = 1'b0,
        WAIT_ALIGN = 1'b1
    } clksw_state_e;

    // Division ratio selected by index sel: 2^(sel+1).
    function automatic int ratio(input int sel);
        return 1 << (sel + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clksw_div_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clksw_div_counter                                            |
// | Description : Free-running NUM_DIVS-bit counter. Bit i of the count is     |
// |               the root clock divided by 2^(i+1). Wraps from all-ones to 0. |
// | Ports       : clk        - root clock                                      |
// |               reset      - asynchronous active-high reset                  |
// |               o_cnt      - current count                                   |
// |               o_cnt_next - count value after the next rising edge          |
// |               o_align    - count is all-ones: every divided clock falls    |
// |                            on the coming edge                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clksw_div_counter #(
    parameter int NUM_DIVS = 4
) (
    input  logic                clk,
    input  logic                reset,
    output logic [NUM_DIVS-1:0] o_cnt,
    output logic [NUM_DIVS-1:0] o_cnt_next,
    output logic                o_align
);

    logic [NUM_DIVS-1:0] r_cnt;
    logic [NUM_DIVS-1:0] w_cnt_next;

    assign w_cnt_next = r_cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign o_cnt      = r_cnt;
    assign o_cnt_next = w_cnt_next;
    assign o_align    = &r_cnt;

endmodule
`default_nettype wire

// File: rtl/clk_switcher_ndiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : clk_switcher_ndiv                                            |
// | Description : Root-clock divider with a glitch-free switch between         |
// |               NUM_DIVS ratios (2, 4, ... 2^NUM_DIVS). A new ratio is       |
// |               requested over a val/rdy handshake and applied only on the   |
// |               alignment edge, where every divided clock falls together.    |
// | Ports       : clk         - root clock                                     |
// |               reset       - asynchronous active-high reset                 |
// |               switch_val  - ratio-change request valid                     |
// |               switch_rdy  - request can be accepted                        |
// |               switch_msg  - requested select index                         |
// |               clk_out     - selected divided clock (flop output)           |
// |               cur_sel     - currently applied select                       |
// |               switch_done - one-cycle pulse after a switch is applied      |
// |               switch_err  - sticky out-of-range flag (CLKSW_ERR_EN only)   |
// | Options     : CLKSW_ERR_EN - out-of-range requests are consumed, flagged   |
// |               and dropped; otherwise they are clamped to NUM_DIVS-1.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module clk_switcher_ndiv
    import clksw_pkg::*;
#(
    parameter int NUM_DIVS  = 4,
    parameter int SEL_W     = $clog2(NUM_DIVS),
    parameter int RESET_SEL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             switch_val,
    output logic             switch_rdy,
    input  logic [SEL_W-1:0] switch_msg,
    output logic             clk_out,
    output logic [SEL_W-1:0] cur_sel,
    output logic             switch_done
`ifdef CLKSW_ERR_EN
    ,
    output logic             switch_err
`endif
);

    localparam logic [SEL_W-1:0] c_reset_sel = SEL_W'(RESET_SEL);
    // One extra bit so NUM_DIVS itself is representable for the range test.
    localparam logic [SEL_W:0]   c_num_divs  = (SEL_W + 1)'(NUM_DIVS);
`ifndef CLKSW_ERR_EN
    localparam logic [SEL_W-1:0] c_max_sel   = SEL_W'(NUM_DIVS - 1);
`endif

    // ------------------------------------------------------------------
    // Divider
    // ------------------------------------------------------------------
    logic [NUM_DIVS-1:0] w_cnt;
    logic [NUM_DIVS-1:0] w_cnt_next;
    logic                w_align;
    logic                w_unused_cnt;

    clksw_div_counter #(
        .NUM_DIVS (NUM_DIVS)
    ) u_div_counter (
        .clk        (clk),
        .reset      (reset),
        .o_cnt      (w_cnt),
        .o_cnt_next (w_cnt_next),
        .o_align    (w_align)
    );

    // The present count is only needed inside the counter for alignment.
    assign w_unused_cnt = ^w_cnt;

    // ------------------------------------------------------------------
    // Switch FSM
    // ------------------------------------------------------------------
    clksw_state_e     r_state;
    clksw_state_e     w_state_next;
    logic [SEL_W-1:0] r_pend_sel;
    logic [SEL_W-1:0] w_pend_sel_next;
    logic [SEL_W-1:0] r_cur_sel;
    logic [SEL_W-1:0] w_cur_sel_next;
    logic             r_clk_out;
    logic             r_done;
    logic             w_apply;
    logic             w_out_of_range;
    logic [SEL_W-1:0] w_msg;
`ifdef CLKSW_ERR_EN
    logic             r_err;
    logic             w_err_set;
`endif

    assign w_out_of_range = ({1'b0, switch_msg} >= c_num_divs);

`ifdef CLKSW_ERR_EN
    assign w_msg = switch_msg;
`else
    assign w_msg = w_out_of_range ? c_max_sel : switch_msg;
`endif

    assign switch_rdy = (r_state == IDLE);

    always_comb begin
        w_state_next    = r_state;
        w_pend_sel_next = r_pend_sel;
        w_apply         = 1'b0;
`ifdef CLKSW_ERR_EN
        w_err_set       = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (switch_val) begin
`ifdef CLKSW_ERR_EN
                    if (w_out_of_range) begin
                        // Consumed but dropped: no switch is scheduled.
                        w_err_set = 1'b1;
                    end else begin
                        w_pend_sel_next = w_msg;
                        w_state_next    = WAIT_ALIGN;
                    end
`else
                    w_pend_sel_next = w_msg;
                    w_state_next    = WAIT_ALIGN;
`endif
                end
            end
            WAIT_ALIGN: begin
                // Entering this state consumes the acceptance edge, so the
                // first align seen here is strictly later than acceptance.
                if (w_align) begin
                    w_apply      = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_cur_sel_next = w_apply ? r_pend_sel : r_cur_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_pend_sel <= '0;
            r_cur_sel  <= c_reset_sel;
            r_clk_out  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pend_sel <= w_pend_sel_next;
            r_cur_sel  <= w_cur_sel_next;
            // A switch only lands where cnt_next is 0, so the new ratio
            // always starts with a full low phase.
            r_clk_out  <= w_cnt_next[w_cur_sel_next];
            r_done     <= w_apply;
        end
    end

`ifdef CLKSW_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    assign switch_err = r_err;
`endif

    assign clk_out     = r_clk_out;
    assign cur_sel     = r_cur_sel;
    assign switch_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_clk_switcher_ndiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_clk_switcher_ndiv                                         |
// | Description : Self-checking bench for clk_switcher_ndiv. Two instances     |
// |               (NUM_DIVS=4 and NUM_DIVS=3) run against a cycle-level        |
// |               reference model built from the divider/switch rules.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_clk_switcher_ndiv;
    import clksw_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       val0, val1;
    logic [1:0] msg0, msg1;
    logic       rdy0, rdy1, co0, co1, done0, done1;
    logic [1:0] sel0, sel1;
`ifdef CLKSW_ERR_EN
    logic       err0, err1;
`endif

    always #5 clk = ~clk;

    clk_switcher_ndiv #(.NUM_DIVS(4), .RESET_SEL(0)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .switch_val  (val0),
        .switch_rdy  (rdy0),
        .switch_msg  (msg0),
        .clk_out     (co0),
        .cur_sel     (sel0),
        .switch_done (done0)
`ifdef CLKSW_ERR_EN
        ,
        .switch_err  (err0)
`endif
    );

    clk_switcher_ndiv #(.NUM_DIVS(3), .RESET_SEL(0)) dut3 (
        .clk         (clk),
        .reset       (reset),
        .switch_val  (val1),
        .switch_rdy  (rdy1),
        .switch_msg  (msg1),
        .clk_out     (co1),
        .cur_sel     (sel1),
        .switch_done (done1)
`ifdef CLKSW_ERR_EN
        ,
        .switch_err  (err1)
`endif
    );

    // Reference model state per instance: edges since reset modulo the
    // wrap period, applied select, edges left until a pending switch lands.
    int nd     [2] = '{4, 3};
    int m_cnt  [2];
    int m_sel  [2];
    int m_wait [2];
    int m_pend [2];
    int m_done [2];
    int m_err  [2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, i, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i]  = 0;
            m_sel[i]  = 0;
            m_wait[i] = 0;
            m_pend[i] = 0;
            m_done[i] = 0;
            m_err[i]  = 0;
        end
    endtask

    task automatic model_edge(input int i, input logic v, input logic [1:0] msg);
        int  period;
        int  tgt;
        bit  drop;
        period    = ratio(nd[i] - 1);
        tgt       = int'(msg);
        drop      = 1'b0;
        m_done[i] = 0;
        if (m_wait[i] > 0) begin
            m_wait[i]--;
            if (m_wait[i] == 0) begin
                m_sel[i]  = m_pend[i];
                m_done[i] = 1;
            end
        end else if (v) begin
            if (tgt >= nd[i]) begin
`ifdef CLKSW_ERR_EN
                m_err[i] = 1;
                drop     = 1'b1;
`else
                tgt = nd[i] - 1;
`endif
            end
            if (!drop) begin
                m_pend[i] = tgt;
                // Edges until the next wrap strictly after this one.
                m_wait[i] = (m_cnt[i] == period - 1) ? period : (period - 1 - m_cnt[i]);
            end
        end
        m_cnt[i] = (m_cnt[i] + 1) % period;
    endtask

    task automatic check_all();
        chk("clk_out", 0, 32'(co0), 32'((m_cnt[0] >> m_sel[0]) & 1));
        chk("cur_sel", 0, 32'(sel0), 32'(m_sel[0]));
        chk("rdy", 0, 32'(rdy0), 32'(m_wait[0] == 0));
        chk("done", 0, 32'(done0), 32'(m_done[0]));
        chk("clk_out", 1, 32'(co1), 32'((m_cnt[1] >> m_sel[1]) & 1));
        chk("cur_sel", 1, 32'(sel1), 32'(m_sel[1]));
        chk("rdy", 1, 32'(rdy1), 32'(m_wait[1] == 0));
        chk("done", 1, 32'(done1), 32'(m_done[1]));
`ifdef CLKSW_ERR_EN
        chk("err", 0, 32'(err0), 32'(m_err[0]));
        chk("err", 1, 32'(err1), 32'(m_err[1]));
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0, val0, msg0);
        model_edge(1, val1, msg1);
        #1;
        check_all();
    endtask

    // Asynchronous reset between edges; outputs must clear without a clock.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        model_reset();
        check_all();
        reset = 1'b0;
    endtask

    task automatic run_to_cnt(input int c);
        for (int k = 0; k < 64 && m_cnt[0] != c; k++) step();
    endtask

    initial begin
        int low;
        int dn;
        reset = 1'b1;
        val0  = 1'b0;
        val1  = 1'b0;
        msg0  = 2'd0;
        msg1  = 2'd0;
        model_reset();
        #12;
        check_all();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) step();

        // Switch to ratio 8, accepted mid-period: 11 cycles not ready.
        run_to_cnt(4);
        val0 = 1'b1;
        msg0 = 2'd2;
        step();
        val0 = 1'b0;
        low  = 0;
        dn   = 0;
        for (int k = 0; k < 40 && rdy0 === 1'b0; k++) begin
            low++;
            step();
            if (done0 === 1'b1) dn++;
        end
        chk("rdy_low_mid", 0, 32'(low), 32'd11);
        chk("done_pulses", 0, 32'(dn), 32'd1);
        chk("sel_is_2", 0, 32'(sel0), 32'd2);
        for (int k = 0; k < 24; k++) step();

        // Acceptance with count all-ones: applied a full wrap later.
        run_to_cnt(15);
        val0 = 1'b1;
        msg0 = 2'd3;
        step();
        val0 = 1'b0;
        low  = 0;
        for (int k = 0; k < 40 && rdy0 === 1'b0; k++) begin
            low++;
            step();
        end
        chk("rdy_low_wrap", 0, 32'(low), 32'd16);
        chk("sel_is_3", 0, 32'(sel0), 32'd3);
        for (int k = 0; k < 40; k++) step();

        // Valid held through WAIT_ALIGN: second message waits for ready.
        val0 = 1'b1;
        msg0 = 2'd1;
        step();
        msg0 = 2'd3;
        for (int k = 0; k < 40 && m_wait[0] != 0; k++) step();
        chk("held_first", 0, 32'(sel0), 32'd1);
        step();
        val0 = 1'b0;
        chk("held_second_acc", 0, 32'(rdy0), 32'd0);
        for (int k = 0; k < 40 && rdy0 !== 1'b1; k++) step();
        chk("held_second", 0, 32'(sel0), 32'd3);

        // Reset while a request is pending.
        run_to_cnt(2);
        val0 = 1'b1;
        msg0 = 2'd1;
        step();
        val0 = 1'b0;
        run_to_cnt(9);
        pulse_reset();
        chk("rst_sel", 0, 32'(sel0), 32'd0);
        for (int k = 0; k < 20; k++) step();

        // Out-of-range request on the three-ratio instance.
        val1 = 1'b1;
        msg1 = 2'd3;
        step();
        val1 = 1'b0;
        for (int k = 0; k < 20 && m_wait[1] != 0; k++) step();
`ifdef CLKSW_ERR_EN
        chk("oor_err", 1, 32'(err1), 32'd1);
        chk("oor_sel", 1, 32'(sel1), 32'd0);
`else
        chk("oor_clamp", 1, 32'(sel1), 32'd2);
`endif
        for (int k = 0; k < 10; k++) step();

        // Random requests and occasional resets against the model.
        for (int n = 0; n < 400; n++) begin
            val0 = ($urandom_range(0, 3) == 0);
            msg0 = 2'($urandom_range(0, 3));
            val1 = ($urandom_range(0, 3) == 0);
            msg1 = 2'($urandom_range(0, 3));
            step();
            if ($urandom_range(0, 99) == 0) begin
                val0 = 1'b0;
                val1 = 1'b0;
                pulse_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
